cleaning_mission_ctrl: RTL and testbench

Mission sequencer for the pipe-cleaning robot FSM. Parks the robot in reset, launches a mission on `start`, and monitors the robot's `front`/`turn`/`remove` commands to count progress. It declares completion when the robot reaches stand-by and aborts on a stuck rotation, a jammed removal or, optionally, a global timeout. Sits between the supervisor (start/status) and the robot FSM, whose synchronous `reset` input it drives.

---
 rtl/cleaning_mission_pkg.sv | 17 +
 rtl/mission_sat_counter.sv | 33 +++
 rtl/cleaning_mission_ctrl.sv | 160 ++++++++++++++++
 tb/tb_cleaning_mission_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cleaning_mission_pkg.sv
// Shared types and abort-cause encodings for the pipe-cleaning mission sequencer.
package cleaning_mission_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StRun,
        StDone,
        StAbort
    } state_e;

    localparam logic [1:0] ABORT_NONE    = 2'd0;
    localparam logic [1:0] ABORT_TURN    = 2'd1;
    localparam logic [1:0] ABORT_REMOVE  = 2'd2;
    localparam logic [1:0] ABORT_TIMEOUT = 2'd3;

endpackage

// File: rtl/mission_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over inc, never wraps.
module mission_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cleaning_mission_ctrl.sv
// Mission sequencer for the pipe-cleaning robot: launch, progress counting, done/abort.
// Optional global RUN timeout enabled by defining MISSION_TIMEOUT_EN.
module cleaning_mission_ctrl
    import cleaning_mission_pkg::*;
#(
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned MAX_TURNS      = 4,
    parameter int unsigned MAX_REMOVE     = 8,
    parameter int unsigned IDLE_CYCLES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             front,
    input  logic             turn,
    input  logic             remove,
    output logic             robot_reset,
    output logic             busy,
    output logic             done,
    output logic             abort,
    output logic [1:0]       abort_code,
    output logic [CNT_W-1:0] step_count,
    output logic [CNT_W-1:0] trash_count
);

    if (MAX_TURNS == 0 || MAX_REMOVE == 0 || IDLE_CYCLES == 0 || TIMEOUT_CYCLES == 0)
    begin : g_bad_cfg
        $error("cleaning_mission_ctrl: thresholds must be non-zero");
    end

    state_e state_q, state_d;

    logic             go_init, in_run;
    logic [CNT_W-1:0] turn_run_q, turn_run_d;
    logic [CNT_W-1:0] rem_run_q, rem_run_d;
    logic [CNT_W-1:0] idle_run_q, idle_run_d;
    logic             rem_prev_q;
    logic [1:0]       abort_code_q, abort_code_d;
    logic             hit_turn, hit_rem, hit_idle, hit_timeout, hit_abort;

    assign in_run  = (state_q == StRun);
    assign go_init = start && (state_q inside {StIdle, StDone, StAbort});

    // Trackers as they will be after this cycle's update; abort checks look at these.
    always_comb begin
        turn_run_d = turn   ? turn_run_q + 1'b1 : '0;
        rem_run_d  = remove ? rem_run_q + 1'b1  : '0;
        idle_run_d = (front || turn || remove) ? '0 : idle_run_q + 1'b1;
    end

    assign hit_turn = in_run && (turn_run_d == CNT_W'(MAX_TURNS));
    assign hit_rem  = in_run && (rem_run_d == CNT_W'(MAX_REMOVE));
    assign hit_idle = in_run && (idle_run_d == CNT_W'(IDLE_CYCLES));

`ifdef MISSION_TIMEOUT_EN
    logic [CNT_W-1:0] run_cycles;

    mission_sat_counter #(.W(CNT_W)) u_timeout_cnt (
        .clock (clock),
        .reset (reset),
        .clear (go_init),
        .inc   (in_run),
        .count (run_cycles)
    );

    assign hit_timeout = in_run && ((run_cycles + 1'b1) == CNT_W'(TIMEOUT_CYCLES));
`else
    assign hit_timeout = 1'b0;
`endif

    assign hit_abort = hit_timeout || hit_turn || hit_rem;

    always_comb begin
        abort_code_d = ABORT_NONE;
        if (hit_timeout) begin
            abort_code_d = ABORT_TIMEOUT;
        end else if (hit_turn) begin
            abort_code_d = ABORT_TURN;
        end else if (hit_rem) begin
            abort_code_d = ABORT_REMOVE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            turn_run_q   <= '0;
            rem_run_q    <= '0;
            idle_run_q   <= '0;
            rem_prev_q   <= 1'b0;
            abort_code_q <= ABORT_NONE;
        end else if (go_init) begin
            turn_run_q   <= '0;
            rem_run_q    <= '0;
            idle_run_q   <= '0;
            rem_prev_q   <= 1'b0;
            abort_code_q <= ABORT_NONE;
        end else if (in_run) begin
            turn_run_q <= turn_run_d;
            rem_run_q  <= rem_run_d;
            idle_run_q <= idle_run_d;
            rem_prev_q <= remove;
            if (hit_abort) begin
                abort_code_q <= abort_code_d;
            end
        end
    end

    mission_sat_counter #(.W(CNT_W)) u_step_cnt (
        .clock (clock),
        .reset (reset),
        .clear (go_init),
        .inc   (in_run && front),
        .count (step_count)
    );

    mission_sat_counter #(.W(CNT_W)) u_trash_cnt (
        .clock (clock),
        .reset (reset),
        .clear (go_init),
        .inc   (in_run && remove && !rem_prev_q),
        .count (trash_count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StInit;
            StInit:  state_d = StRun;
            StRun: begin
                if (hit_abort) begin
                    state_d = StAbort;
                end else if (hit_idle) begin
                    state_d = StDone;
                end
            end
            StDone:  if (start) state_d = StInit;
            StAbort: if (start) state_d = StInit;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        robot_reset = (state_q != StRun);
        busy        = (state_q == StInit) || (state_q == StRun);
        done        = (state_q == StDone);
        abort       = (state_q == StAbort);
    end

    assign abort_code = abort_code_q;

endmodule

// File: tb/tb_cleaning_mission_ctrl.sv
// Scoreboard bench for cleaning_mission_ctrl; honours MISSION_TIMEOUT_EN like the RTL.
module tb_cleaning_mission_ctrl;

    logic        clock = 1'b0;
    logic        reset, start, front, turn, remove;
    logic        robot_reset, busy, done, abort;
    logic [1:0]  abort_code;
    logic [15:0] step_count, trash_count;

    typedef struct {
        string       name;
        logic        dn;
        logic        ab;
        logic [1:0]  code;
        logic [15:0] step;
        logic [15:0] trash;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic prev_fin;

    always #5 clock = ~clock;

    cleaning_mission_ctrl #(
        .CNT_W          (16),
        .MAX_TURNS      (4),
        .MAX_REMOVE     (8),
        .IDLE_CYCLES    (2),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .front       (front),
        .turn        (turn),
        .remove      (remove),
        .robot_reset (robot_reset),
        .busy        (busy),
        .done        (done),
        .abort       (abort),
        .abort_code  (abort_code),
        .step_count  (step_count),
        .trash_count (trash_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cmd(input logic f, input logic t, input logic r);
        front  = f;
        turn   = t;
        remove = r;
        tick();
    endtask

    task automatic expect_end(input string nm, input logic dn, input logic ab,
                              input logic [1:0] code, input logic [15:0] step,
                              input logic [15:0] trash);
        exp_t e;
        e.name  = nm;
        e.dn    = dn;
        e.ab    = ab;
        e.code  = code;
        e.step  = step;
        e.trash = trash;
        sb.push_back(e);
    endtask

    task automatic launch();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("init_busy", 32'(busy), 32'd1);
        chk("init_robot_reset", 32'(robot_reset), 32'd1);
        chk("init_step_clear", 32'(step_count), 32'd0);
        chk("init_trash_clear", 32'(trash_count), 32'd0);
        tick();
        chk("run_robot_reset", 32'(robot_reset), 32'd0);
    endtask

    task automatic wait_drain(input string nm);
        int k = 0;
        while (sb.size() != 0 && k < 10) begin
            tick();
            k++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got no completion, expected done/abort within 10 cycles", nm);
            sb.delete();
        end
    endtask

    // Monitor: scores each rising completion against the oldest queued expectation.
    initial begin
        exp_t e;
        prev_fin = 1'b0;
        forever begin
            @(negedge clock);
            if ((done || abort) && !prev_fin) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_end: got done=%0b abort=%0b, expected none",
                             done, abort);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_done"}, 32'(done), 32'(e.dn));
                    chk({e.name, "_abort"}, 32'(abort), 32'(e.ab));
                    chk({e.name, "_code"}, 32'(abort_code), 32'(e.code));
                    chk({e.name, "_step"}, 32'(step_count), 32'(e.step));
                    chk({e.name, "_trash"}, 32'(trash_count), 32'(e.trash));
                    chk({e.name, "_busy"}, 32'(busy), 32'd0);
                end
            end
            prev_fin = done || abort;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        front  = 1'b0;
        turn   = 1'b0;
        remove = 1'b0;
        tick();
        tick();
        chk("rst_robot_reset", 32'(robot_reset), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_abort", 32'(abort), 32'd0);
        chk("rst_code", 32'(abort_code), 32'd0);
        chk("rst_step", 32'(step_count), 32'd0);
        chk("rst_trash", 32'(trash_count), 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_robot_reset", 32'(robot_reset), 32'd1);

        // Five forward steps then two idle cycles.
        expect_end("fwd5", 1'b1, 1'b0, 2'd0, 16'd5, 16'd0);
        launch();
        for (int i = 0; i < 5; i++) cmd(1'b1, 1'b0, 1'b0);
        cmd(1'b0, 1'b0, 1'b0);
        cmd(1'b0, 1'b0, 1'b0);
        wait_drain("fwd5");

        // Restart from DONE; four consecutive turns is a stuck rotation.
        expect_end("stuck", 1'b0, 1'b1, 2'd1, 16'd0, 16'd0);
        launch();
        for (int i = 0; i < 4; i++) cmd(1'b0, 1'b1, 1'b0);
        wait_drain("stuck");

        // Turn runs broken by a front step never reach the limit.
        expect_end("turns33", 1'b1, 1'b0, 2'd0, 16'd1, 16'd0);
        launch();
        for (int i = 0; i < 3; i++) cmd(1'b0, 1'b1, 1'b0);
        cmd(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cmd(1'b0, 1'b1, 1'b0);
        cmd(1'b0, 1'b0, 1'b0);
        cmd(1'b0, 1'b0, 1'b0);
        wait_drain("turns33");

        // Remove pattern 1,0,1,1,0 gives two rising edges, then idle completes.
        expect_end("trash2", 1'b1, 1'b0, 2'd0, 16'd0, 16'd2);
        launch();
        cmd(1'b0, 1'b0, 1'b1);
        cmd(1'b0, 1'b0, 1'b0);
        cmd(1'b0, 1'b0, 1'b1);
        cmd(1'b0, 1'b0, 1'b1);
        cmd(1'b0, 1'b0, 1'b0);
        cmd(1'b0, 1'b0, 1'b0);
        wait_drain("trash2");

        // Remove held for eight cycles jams.
        expect_end("jam", 1'b0, 1'b1, 2'd2, 16'd0, 16'd1);
        launch();
        for (int i = 0; i < 8; i++) cmd(1'b0, 1'b0, 1'b1);
        remove = 1'b0;
        wait_drain("jam");

        // Alternating front/turn never idles and never hits the turn limit.
`ifdef MISSION_TIMEOUT_EN
        expect_end("timeout", 1'b0, 1'b1, 2'd3, 16'd10, 16'd0);
        launch();
        for (int i = 0; i < 20; i++) cmd(i % 2 == 0, i % 2 == 1, 1'b0);
        front = 1'b0;
        turn  = 1'b0;
        wait_drain("timeout");
`else
        expect_end("no_timeout", 1'b1, 1'b0, 2'd0, 16'd11, 16'd0);
        launch();
        for (int i = 0; i < 21; i++) cmd(i % 2 == 0, i % 2 == 1, 1'b0);
        chk("no_timeout_busy", 32'(busy), 32'd1);
        cmd(1'b0, 1'b0, 1'b0);
        cmd(1'b0, 1'b0, 1'b0);
        wait_drain("no_timeout");
`endif

        // Asynchronous reset in the middle of RUN.
        launch();
        for (int i = 0; i < 3; i++) cmd(1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk("mid_rst_robot_reset", 32'(robot_reset), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_abort", 32'(abort), 32'd0);
        chk("mid_rst_step", 32'(step_count), 32'd0);
        front = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        chk("queue_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
